// File: rtl/fetch_sequencer.sv
// Handshaked instruction fetch controller: owns the PC and issues one outstanding imem request at a time.
// Optional FETCH_PERF_EN adds fetch_count/redirect_count performance counters.
module fetch_sequencer #(
  parameter int unsigned          DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  output logic                  if_valid,
  input  logic                  if_ready,
  output logic [DATA_WIDTH-1:0] if_instr,
  output logic [DATA_WIDTH-1:0] if_pc,
`ifdef FETCH_PERF_EN
  output logic [31:0]           fetch_count,
  output logic [31:0]           redirect_count,
`endif
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] pc;
  logic                  drop;
  logic [DATA_WIDTH-1:0] target;
  logic                  unused_low_bits;

  assign target          = {redirect_pc[DATA_WIDTH-1:2], 2'b00};
  assign unused_low_bits = ^redirect_pc[1:0];

  assign imem_req_valid = (state == REQ);
  assign imem_addr      = pc;
  // A redirect in HOLD kills the presented instruction in the same cycle.
  assign if_valid       = (state == HOLD) && !redirect_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      pc       <= RESET_VECTOR;
      drop     <= 1'b0;
      if_instr <= '0;
      if_pc    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (redirect_valid) pc <= target;
          state <= REQ;
        end
        REQ: begin
          if (redirect_valid) pc <= target;
          if (imem_req_ready) begin
            state <= WAIT;
            drop  <= redirect_valid;
          end
        end
        WAIT: begin
          if (redirect_valid) pc <= target;
          if (imem_rsp_valid) begin
            if (drop || redirect_valid) begin
              drop  <= 1'b0;
              state <= REQ;
            end else begin
              if_instr <= imem_rsp_data;
              if_pc    <= pc;
              state    <= HOLD;
            end
          end else if (redirect_valid) begin
            drop <= 1'b1;
          end
        end
        HOLD: begin
          if (redirect_valid) begin
            pc    <= target;
            state <= REQ;
          end else if (if_ready) begin
            pc    <= pc + DATA_WIDTH'(4);
            state <= REQ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_count    <= '0;
      redirect_count <= '0;
    end else begin
      if (if_valid && if_ready) fetch_count    <= fetch_count + 32'd1;
      if (redirect_valid)       redirect_count <= redirect_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer; imem model returns ~addr as the instruction word.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count;
  logic [31:0] redirect_count;
`endif

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic        pend;
  logic [31:0] pend_data;
  logic        mem_stall;

  always #5 clk = ~clk;

  fetch_sequencer #(
    .DATA_WIDTH   (32),
    .RESET_VECTOR (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
`ifdef FETCH_PERF_EN
    .fetch_count    (fetch_count),
    .redirect_count (redirect_count),
`endif
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: memory accepts on the edge, responds after it unless stalled.
  task automatic tick();
    logic        acc;
    logic [31:0] a;
    acc = imem_req_valid && imem_req_ready;
    a   = imem_addr;
    @(posedge clk);
    #1;
    if (acc) begin
      pend      = 1'b1;
      pend_data = ~a;
    end
    if (pend && !mem_stall) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = pend_data;
      pend           = 1'b0;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  endtask

  task automatic expect_req(input string tag, input logic [31:0] addr);
    chk({tag, "_req_valid"}, {31'd0, imem_req_valid}, 32'd1);
    chk({tag, "_addr"}, imem_addr, addr);
    chk({tag, "_if_valid"}, {31'd0, if_valid}, 32'd0);
  endtask

  task automatic expect_hold(input string tag, input logic [31:0] pc, input logic [31:0] instr);
    chk({tag, "_if_valid"}, {31'd0, if_valid}, 32'd1);
    chk({tag, "_if_pc"}, if_pc, pc);
    chk({tag, "_if_instr"}, if_instr, instr);
    chk({tag, "_req_valid"}, {31'd0, imem_req_valid}, 32'd0);
  endtask

  logic [31:0] run_pc    [3] = '{32'h0000_0000, 32'h0000_0004, 32'h0000_0008};
  logic [31:0] run_instr [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFB, 32'hFFFF_FFF7};

  initial begin
    rst            = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if_ready       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    pend           = 1'b0;
    pend_data      = '0;
    mem_stall      = 1'b0;

    @(posedge clk);
    #1;
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_instr", if_instr, 32'h0);
    #3 rst = 1'b1;

    // IDLE -> REQ, then three back-to-back fetches at one per three cycles.
    tick();
    for (int i = 0; i < 3; i++) begin
      expect_req("run", run_pc[i]);
      tick();
      chk("run_wait_req", {31'd0, imem_req_valid}, 32'd0);
      chk("run_wait_ifv", {31'd0, if_valid}, 32'd0);
      tick();
      expect_hold("run", run_pc[i], run_instr[i]);
      tick();
    end

    // Backpressure in HOLD for five cycles.
    expect_req("bp", 32'h0000_000C);
    tick();
    if_ready = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      expect_hold("bp", 32'h0000_000C, 32'hFFFF_FFF3);
      tick();
    end
    expect_hold("bp_last", 32'h0000_000C, 32'hFFFF_FFF3);
    if_ready = 1'b1;
    tick();
    expect_req("bp_next", 32'h0000_0010);

    // Redirect while the fetch of 0x10 is outstanding; its response must be dropped.
    mem_stall = 1'b1;
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    chk("rw_req_valid", {31'd0, imem_req_valid}, 32'd0);
    tick();
    redirect_valid = 1'b0;
    mem_stall      = 1'b0;
    tick();
    chk("rw_rsp_present", {31'd0, imem_rsp_valid}, 32'd1);
    chk("rw_no_ifv", {31'd0, if_valid}, 32'd0);
    tick();
    chk("rw_no_ifv2", {31'd0, if_valid}, 32'd0);
    expect_req("rw_refetch", 32'h0000_0100);
    tick();
    tick();
    expect_hold("rw", 32'h0000_0100, 32'hFFFF_FEFF);

    // Redirect in HOLD with if_ready=1: instruction killed, target fetched next.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    #1;
    chk("rh_killed", {31'd0, if_valid}, 32'd0);
    tick();
    redirect_valid = 1'b0;
    expect_req("rh_target", 32'hFFFF_FFFC);
    tick();
    tick();
    expect_hold("wrap", 32'hFFFF_FFFC, 32'h0000_0003);
    tick();
    expect_req("wrap_next", 32'h0000_0000);
`ifdef FETCH_PERF_EN
    chk("perf_fetch", fetch_count, 32'd5);
    chk("perf_redirect", redirect_count, 32'd2);
`endif

    // Asynchronous reset between edges while in WAIT.
    mem_stall = 1'b1;
    tick();
    chk("ar_in_wait", {31'd0, imem_req_valid}, 32'd0);
    #2 rst = 1'b0;
    #1;
    chk("ar_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("ar_if_valid", {31'd0, if_valid}, 32'd0);
    chk("ar_addr", imem_addr, 32'h0);
    chk("ar_if_pc", if_pc, 32'h0);
`ifdef FETCH_PERF_EN
    chk("ar_fetch_cnt", fetch_count, 32'd0);
    chk("ar_redir_cnt", redirect_count, 32'd0);
`endif
    pend      = 1'b0;
    mem_stall = 1'b0;
    #2 rst = 1'b1;
    tick();
    expect_req("ar_restart", 32'h0000_0000);
    tick();
    tick();
    expect_hold("ar_restart", 32'h0000_0000, 32'hFFFF_FFFF);
    tick();
    expect_req("ar_next", 32'h0000_0004);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
